// File: rtl/fabric_unmap_tag.sv
// fabric_unmap_tag: restores a wide tag from a narrowed one via reverse CAM
// lookup of the packed {valid, src_tag, dst_tag} table; output through a
// 2-entry skid buffer (latency 1, full rate).
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data
// {narrow tag, value}; out_valid/out_ready/out_data {wide tag, value};
// cfg_data packed table; error_valid/error_code sticky first error;
// drop_count saturating count of unmatched tokens.
module fabric_unmap_tag #(
    parameter int DATA_WIDTH       = 32,
    parameter int NARROW_TAG_WIDTH = 2,
    parameter int WIDE_TAG_WIDTH   = 4,
    parameter int TABLE_SIZE       = 4,
    localparam int ENTRY_WIDTH     = 1 + WIDE_TAG_WIDTH + NARROW_TAG_WIDTH,
    localparam int CONFIG_WIDTH    = TABLE_SIZE * ENTRY_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH+NARROW_TAG_WIDTH-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH+WIDE_TAG_WIDTH-1:0] out_data,
    input  logic [CONFIG_WIDTH-1:0]              cfg_data,
    output logic                                 error_valid,
    output logic [15:0]                          error_code,
    output logic [15:0]                          drop_count
);

    localparam logic [15:0] CFG_UNMAP_TAG_DUP_TAG = 16'h0C01;
    localparam logic [15:0] RT_UNMAP_TAG_NO_MATCH = 16'h0C02;

    localparam int NW = NARROW_TAG_WIDTH;
    localparam int WW = WIDE_TAG_WIDTH;
    localparam int OW = DATA_WIDTH + WIDE_TAG_WIDTH;

    if (DATA_WIDTH < 1) begin : g_chk_dw
        $fatal(1, "COMP_UNMAP_TAG_DATA_WIDTH");
    end
    if (NARROW_TAG_WIDTH < 1) begin : g_chk_nw
        $fatal(1, "COMP_UNMAP_TAG_NARROW_TAG_WIDTH");
    end
    if (WIDE_TAG_WIDTH < 1) begin : g_chk_ww
        $fatal(1, "COMP_UNMAP_TAG_WIDE_TAG_WIDTH");
    end
    if (TABLE_SIZE < 1) begin : g_chk_ts
        $fatal(1, "COMP_UNMAP_TAG_TABLE_SIZE");
    end

    logic          w_ent_v   [TABLE_SIZE];
    logic [WW-1:0] w_ent_src [TABLE_SIZE];
    logic [NW-1:0] w_ent_dst [TABLE_SIZE];

    for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_ent
        assign w_ent_v[g]   = cfg_data[g*ENTRY_WIDTH + ENTRY_WIDTH - 1];
        assign w_ent_src[g] = cfg_data[g*ENTRY_WIDTH + NW +: WW];
        assign w_ent_dst[g] = cfg_data[g*ENTRY_WIDTH +: NW];
    end

    logic [NW-1:0]         w_in_tag;
    logic [DATA_WIDTH-1:0] w_in_val;
    logic                  w_hit;
    logic [WW-1:0]         w_src;
    logic                  w_dup;

    assign w_in_tag = in_data[DATA_WIDTH +: NW];
    assign w_in_val = in_data[DATA_WIDTH-1:0];

    // Scan downwards so the lowest matching index is the last writer.
    always_comb begin
        w_hit = 1'b0;
        w_src = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (w_ent_v[i] && (w_ent_dst[i] == w_in_tag)) begin
                w_hit = 1'b1;
                w_src = w_ent_src[i];
            end
        end
    end

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            for (int j = i + 1; j < TABLE_SIZE; j++) begin
                if (w_ent_v[i] && w_ent_v[j] &&
                    (w_ent_dst[i] == w_ent_dst[j]))
                    w_dup = 1'b1;
            end
        end
    end

    logic          r_m_valid;
    logic [OW-1:0] r_m_data;
    logic          r_s_valid;
    logic [OW-1:0] r_s_data;
    logic          r_err_valid;
    logic [15:0]   r_err_code;
    logic [15:0]   r_drop_cnt;

    logic          w_acc;
    logic          w_fire;
    logic          w_push;
    logic          w_drop;
    logic [OW-1:0] w_new;

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready = !r_s_valid;
    assign w_acc    = in_valid && in_ready;
    assign w_fire   = r_m_valid && out_ready;
    assign w_push   = w_acc && w_hit;
    assign w_drop   = w_acc && !w_hit;
    assign w_new    = {w_src, w_in_val};

    // An accept implies the skid is empty, so the push below never
    // collides with an S->M transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else begin
            if (w_fire) begin
                if (r_s_valid) begin
                    r_m_data  <= r_s_data;
                    r_s_valid <= 1'b0;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
            if (w_push) begin
                if (!r_m_valid || w_fire) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_new;
                end else begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= w_new;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (!r_err_valid) begin
                if (w_dup) begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= CFG_UNMAP_TAG_DUP_TAG;
                end else if (w_drop) begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= RT_UNMAP_TAG_NO_MATCH;
                end
            end
        end
    end

    assign out_valid   = r_m_valid;
    assign out_data    = r_m_data;
    assign error_valid = r_err_valid;
    assign error_code  = r_err_code;
    assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_fabric_unmap_tag.sv
// tb_fabric_unmap_tag: directed self-checking bench for fabric_unmap_tag.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_fabric_unmap_tag;

    localparam int DW = 32;
    localparam int NW = 2;
    localparam int WW = 4;
    localparam int TS = 4;
    localparam int EW = 1 + WW + NW;

    localparam logic [15:0] CFG_DUP  = 16'h0C01;
    localparam logic [15:0] RT_NOMAT = 16'h0C02;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW+NW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW+WW-1:0]  out_data;
    logic [TS*EW-1:0]  cfg_data;
    logic              error_valid;
    logic [15:0]       error_code;
    logic [15:0]       drop_count;

    int checks;
    int failures;

    fabric_unmap_tag #(
        .DATA_WIDTH(DW),
        .NARROW_TAG_WIDTH(NW),
        .WIDE_TAG_WIDTH(WW),
        .TABLE_SIZE(TS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cfg_data(cfg_data),
        .error_valid(error_valid),
        .error_code(error_code),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int idx, input logic v,
                             input logic [WW-1:0] src,
                             input logic [NW-1:0] dst);
        cfg_data[idx*EW +: EW] = {v, src, dst};
    endtask

    task automatic base_cfg();
        cfg_data = '0;
        set_entry(0, 1'b1, 4'hA, 2'd1);
        set_entry(1, 1'b1, 4'h3, 2'd2);
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        base_cfg();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL rst_out_data got=%h exp=0", out_data);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (error_valid !== 1'b0 || error_code !== 16'h0) begin
            failures++;
            $display("FAIL rst_error got=%b/%h exp=0/0000",
                     error_valid, error_code);
        end
        checks++;
        if (drop_count !== 16'h0) begin
            failures++;
            $display("FAIL rst_drop got=%h exp=0000", drop_count);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {2'd1, 32'hDEADBEEF};
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pre_valid got=%b exp=0", out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4'hA, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_out got=%b/%h exp=1/a%h",
                     out_valid, out_data, 32'hDEADBEEF);
        end
        checks++;
        if (error_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_err got=%b exp=0", error_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] tags [4];
        logic [WW-1:0] exp_tag [4];
        tags[0] = 2'd2; tags[1] = 2'd1; tags[2] = 2'd2; tags[3] = 2'd1;
        exp_tag[0] = 4'h3; exp_tag[1] = 4'hA;
        exp_tag[2] = 4'h3; exp_tag[3] = 4'hA;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = {tags[k], 32'h1000_0000 + 32'(k)};
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b exp=1", k, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 ||
                out_data !== {exp_tag[k], 32'h1000_0000 + 32'(k)}) begin
                failures++;
                $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h%h", k,
                         out_valid, out_data, exp_tag[k],
                         32'h1000_0000 + 32'(k));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {2'd1, 32'h0000_0100};
        step();
        in_data = {2'd2, 32'h0000_0101};
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready1 got=%b exp=1", in_ready);
        end
        step();
        in_data = {2'd1, 32'h0000_0102};
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_full got=%b exp=0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== {4'hA, 32'h0000_0100}) begin
                failures++;
                $display("FAIL bp_stall[%0d] got=%b/%h exp=1/a00000100",
                         c, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4'h3, 32'h0000_0101}) begin
            failures++;
            $display("FAIL bp_out1 got=%b/%h exp=1/300000101",
                     out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_after got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4'hA, 32'h0000_0102}) begin
            failures++;
            $display("FAIL bp_out2 got=%b/%h exp=1/a00000102",
                     out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_drop();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {2'd3, 32'h0000_0055};
        step();
        in_data = {2'd1, 32'h0000_0077};
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_fwd got=%b exp=0", out_valid);
        end
        checks++;
        if (drop_count !== 16'd1) begin
            failures++;
            $display("FAIL drop_count got=%0d exp=1", drop_count);
        end
        checks++;
        if (error_valid !== 1'b1 || error_code !== RT_NOMAT) begin
            failures++;
            $display("FAIL drop_err got=%b/%h exp=1/%h",
                     error_valid, error_code, RT_NOMAT);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4'hA, 32'h0000_0077}) begin
            failures++;
            $display("FAIL drop_next got=%b/%h exp=1/a00000077",
                     out_valid, out_data);
        end
        step();
    endtask

    task automatic test_dup();
        apply_reset();
        out_ready = 1'b1;
        set_entry(2, 1'b1, 4'h5, 2'd1);
        in_valid = 1'b1;
        in_data  = {2'd3, 32'h0000_0011};
        step();
        in_data = {2'd3, 32'h0000_0012};
        checks++;
        if (error_valid !== 1'b1 || error_code !== CFG_DUP) begin
            failures++;
            $display("FAIL dup_code got=%b/%h exp=1/%h",
                     error_valid, error_code, CFG_DUP);
        end
        step();
        in_data = {2'd1, 32'h0000_0013};
        checks++;
        if (error_code !== CFG_DUP || drop_count !== 16'd2) begin
            failures++;
            $display("FAIL dup_hold got=%h/%0d exp=%h/2",
                     error_code, drop_count, CFG_DUP);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4'hA, 32'h0000_0013}) begin
            failures++;
            $display("FAIL dup_lowest got=%b/%h exp=1/a00000013",
                     out_valid, out_data);
        end
        step();
        base_cfg();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {2'd1, 32'h0000_0AAA};
        step();
        in_data = {2'd2, 32'h0000_0BBB};
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_async got=%b/%h exp=0/0",
                     out_valid, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || drop_count !== 16'd0 ||
            error_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release got=%b/%0d/%b exp=1/0/0",
                     in_ready, drop_count, error_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale[%0d] got=%b exp=0", c, out_valid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_dup();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fabric_unmap_tag.md
Name: fabric_unmap_tag

Overview:
- Receive-side counterpart of the tag-mapping stage: restores the original wide tag on a tagged stream whose tag was narrowed upstream.
- Uses a CAM-style reverse lookup on the same packed table format the mapping stage uses, matching on the dst_tag field and emitting src_tag.
- Output is registered through a 2-entry skid buffer: latency 1, full throughput.
- Unmatched tokens are dropped and counted, and errors are latched for the fabric error network.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>= 1).
- NARROW_TAG_WIDTH, 2, incoming tag width (>= 1).
- WIDE_TAG_WIDTH, 4, restored tag width (>= 1).
- TABLE_SIZE, 4, number of table entries (>= 1).
- ENTRY_WIDTH (localparam), 1+WIDE_TAG_WIDTH+NARROW_TAG_WIDTH.
- CONFIG_WIDTH (localparam), TABLE_SIZE*ENTRY_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input token valid.
- in_ready  out  1  input accept.
- in_data  in  DATA_WIDTH+NARROW_TAG_WIDTH  {tag, value}; tag in MSBs.
- out_valid  out  1  output token valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH+WIDE_TAG_WIDTH  {restored tag, value}.
- cfg_data  in  CONFIG_WIDTH  entry i at [i*ENTRY_WIDTH +: ENTRY_WIDTH] = {valid, src_tag(WIDE), dst_tag(NARROW)}; dst_tag in LSBs.
- error_valid  out  1  sticky error flag.
- error_code  out  16  first error code.
- drop_count  out  16  saturating count of dropped tokens.

Behaviour:
- Clocking and reset: one clock domain, clk, with asynchronous active-low reset rst_n.
- Reset values: out_valid=0, out_data=0, skid empty, in_ready=1 after reset deasserts, error_valid=0, error_code=0, drop_count=0.
- Elaboration checks: $fatal if any width or TABLE_SIZE parameter is < 1. Codes COMP_UNMAP_TAG_DATA_WIDTH, COMP_UNMAP_TAG_NARROW_TAG_WIDTH, COMP_UNMAP_TAG_WIDE_TAG_WIDTH, COMP_UNMAP_TAG_TABLE_SIZE.
- Lookup (combinational on the input side):
  - match_vec[i] = valid_i && dst_tag_i == in_tag.
  - Lowest matching index wins.
  - Payload passes through unchanged.
- Buffer: main register M (drives out_*) plus skid register S.
  - in_ready = !S.valid (registered, never combinational from out_ready).
  - Accept = in_valid && in_ready.
- Matched accept:
  - If M is empty, or M fires (out_valid && out_ready) this cycle, the token loads into M.
  - Otherwise it loads into S.
- Buffer drain:
  - When M fires and S is valid, S moves to M and S clears.
  - Order is strictly preserved.
- Unmatched accept:
  - The token is consumed (not forwarded) and never enters M or S.
  - drop_count increments, saturating at 16'hFFFF.
- Latency: 1 cycle from accept to out_valid when M is empty.
- Throughput: 1 token/cycle with out_ready held high.
- Backpressure: with out_ready low, accepts at most 2 tokens, then in_ready=0 until M fires.
- Output stability: out_data is held stable while out_valid && !out_ready.
- Config updates: cfg_data is static during traffic. A change affects only tokens accepted after the change; tokens already in M/S are unaffected.
- CFG error CFG_UNMAP_TAG_DUP_TAG: two valid entries share the same dst_tag. Evaluated every cycle regardless of traffic.
- RT error RT_UNMAP_TAG_NO_MATCH: an unmatched accept.
- Error latch:
  - Captures the first error only; CFG has priority over RT in the same cycle.
  - Held until reset.
  - Datapath keeps running after an error.
  - Both error codes are added to fabric_common.svh.
- Reset mid-operation: buffered tokens are discarded; outputs return to reset values asynchronously.

Test Plan:
- DATA_WIDTH=32, NARROW=2, WIDE=4. Table {1,4'hA,2'd1}, {1,4'h3,2'd2}, others invalid. Inject tag 1/value 32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data={4'hA,32'hDEADBEEF}; no error.
- Stream tags 2,1,2,1 back-to-back with out_ready=1 -> outputs 3,A,3,A on consecutive cycles; in_ready stays 1.
- out_ready=0, offer 3 tokens -> first two accepted, in_ready=0 on the cycle after the second. Raise out_ready -> all 3 emerge in order; out_data stable while stalled.
- Inject tag 3 (no entry) -> token dropped, drop_count=1, error_valid=1, error_code=RT_UNMAP_TAG_NO_MATCH. A following tag-1 token is still delivered.
- Entries 0 and 2 both valid with dst_tag 2'd1, same cycle as an unmatched token -> error_code=CFG_UNMAP_TAG_DUP_TAG; a later RT error does not overwrite it.
- Fill M and S under stall, assert rst_n=0 mid-cycle -> out_valid drops immediately. After release: in_ready=1, drop_count=0, error_valid=0, no stale token emitted.
